// File: rtl/irq_ctrl_if.sv
// Bus interface between the CPU external-bus decoder and the interrupt
// controller register file. Read and write data are already split.
`timescale 1ns/1ps

interface irq_ctrl_if;
    logic        i_sel;
    logic        i_rw;
    logic [15:0] i_addr;
    logic [15:0] i_wdata;
    logic [15:0] o_rdata;
    logic        o_rdata_vld;

    modport master (
        output i_sel,
        output i_rw,
        output i_addr,
        output i_wdata,
        input  o_rdata,
        input  o_rdata_vld
    );

    modport slave (
        input  i_sel,
        input  i_rw,
        input  i_addr,
        input  i_wdata,
        output o_rdata,
        output o_rdata_vld
    );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises asynchronous sources, latches rising
// edges as pending bits, masks/routes them onto two request lines and
// exposes PEND/EN/ROUTE/VEC/CLAIM registers on the CPU bus.
`timescale 1ns/1ps

module irq_ctrl #(
    parameter int          N_SRC       = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] BASE_ADDR   = 16'hFF00
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [N_SRC-1:0] i_irq_src,
    irq_ctrl_if.slave        bus,
    output logic             o_inta,
    output logic             o_intb
);

    localparam logic [15:0] OFF_PEND  = 16'd0;
    localparam logic [15:0] OFF_EN    = 16'd1;
    localparam logic [15:0] OFF_ROUTE = 16'd2;
    localparam logic [15:0] OFF_VEC   = 16'd3;
    localparam logic [15:0] OFF_CLAIM = 16'd4;
    localparam logic [15:0] N_REGS    = 16'd5;
    localparam logic [15:0] NO_WINNER = 16'h00FF;

    // Index of the lowest set bit, or NO_WINNER when the vector is empty.
    function automatic logic [15:0] lowest_idx(input logic [N_SRC-1:0] v);
        logic [15:0] idx;
        idx = NO_WINNER;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            idx = v[i] ? 16'(i) : idx;
        end
        return idx;
    endfunction

    // Zero-extend an N_SRC-wide register to the 16-bit bus width.
    function automatic logic [15:0] zext(input logic [N_SRC-1:0] v);
        logic [15:0] w;
        w = 16'h0000;
        w[N_SRC-1:0] = v;
        return w;
    endfunction

    logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q, sync_d;
    logic [N_SRC-1:0] hist_q, hist_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] en_q, en_d;
    logic [N_SRC-1:0] route_q, route_d;
    logic [15:0]      rdata_q, rdata_d;
    logic             rdata_vld_q, rdata_vld_d;
    logic             inta_q, inta_d;
    logic             intb_q, intb_d;

    logic [N_SRC-1:0] sync_out_s;
    logic [N_SRC-1:0] rise_s;
    logic [N_SRC-1:0] cand_hi_s;
    logic [N_SRC-1:0] cand_lo_s;
    logic [N_SRC-1:0] cand_s;
    logic [N_SRC-1:0] win_oh_s;
    logic [15:0]      win_idx_s;
    logic [15:0]      offset_s;
    logic             in_range_s;
    logic             wr_en_s;
    logic             rd_en_s;
    logic [N_SRC-1:0] wdata_s;
    logic             unused_wdata_s;

    assign sync_out_s = sync_q[SYNC_STAGES-1];
    assign rise_s     = sync_out_s & ~hist_q;

    // Address offset wraps, so addresses below BASE_ADDR land far out of range.
    assign offset_s   = bus.i_addr - BASE_ADDR;
    assign in_range_s = (offset_s < N_REGS);
    assign wr_en_s    = bus.i_sel & ~bus.i_rw & in_range_s;
    assign rd_en_s    = bus.i_sel & bus.i_rw & in_range_s;
    assign wdata_s    = bus.i_wdata[N_SRC-1:0];
    assign unused_wdata_s = ^bus.i_wdata;

    // High-priority group wins outright; lowest index wins inside a group.
    assign cand_hi_s = pend_q & en_q & route_q;
    assign cand_lo_s = pend_q & en_q & ~route_q;
    assign cand_s    = (|cand_hi_s) ? cand_hi_s : cand_lo_s;
    assign win_oh_s  = cand_s & (~cand_s + N_SRC'(1'b1));
    assign win_idx_s = lowest_idx(cand_s);

    // Synchroniser shift and edge-detect history advance every cycle.
    always_comb begin
        sync_d = sync_q;
        sync_d[0] = i_irq_src;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        hist_d = sync_out_s;
    end

    // Register file: writes, reads, claim, and pending-bit set/clear merge.
    always_comb begin
        pend_d      = pend_q;
        en_d        = en_q;
        route_d     = route_q;
        rdata_d     = rdata_q;
        rdata_vld_d = 1'b0;

        if (wr_en_s) begin
            case (offset_s)
                OFF_PEND:  pend_d  = pend_q & ~wdata_s;
                OFF_EN:    en_d    = wdata_s;
                OFF_ROUTE: route_d = wdata_s;
                default:   pend_d  = pend_q;
            endcase
        end else begin
            pend_d = pend_q;
        end

        if (rd_en_s) begin
            rdata_vld_d = 1'b1;
            case (offset_s)
                OFF_PEND:  rdata_d = zext(pend_q);
                OFF_EN:    rdata_d = zext(en_q);
                OFF_ROUTE: rdata_d = zext(route_q);
                OFF_VEC:   rdata_d = win_idx_s;
                OFF_CLAIM: begin
                    rdata_d = win_idx_s;
                    pend_d  = pend_q & ~win_oh_s;
                end
                default:   rdata_d = rdata_q;
            endcase
        end else begin
            rdata_vld_d = 1'b0;
        end

        // A new edge in the same cycle as a clear keeps the bit set.
        pend_d = pend_d | rise_s;
    end

    // Request lines reflect the registered state of the previous cycle.
    always_comb begin
        intb_d = |(pend_q & en_q & route_q);
        inta_d = |(pend_q & en_q & ~route_q);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q      <= '0;
            hist_q      <= '0;
            pend_q      <= '0;
            en_q        <= '0;
            route_q     <= '0;
            rdata_q     <= 16'h0000;
            rdata_vld_q <= 1'b0;
            inta_q      <= 1'b0;
            intb_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            hist_q      <= hist_d;
            pend_q      <= pend_d;
            en_q        <= en_d;
            route_q     <= route_d;
            rdata_q     <= rdata_d;
            rdata_vld_q <= rdata_vld_d;
            inta_q      <= inta_d;
            intb_q      <= intb_d;
        end
    end

    assign bus.o_rdata     = rdata_q;
    assign bus.o_rdata_vld = rdata_vld_q;
    assign o_inta          = inta_q;
    assign o_intb          = intb_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: bus reads push expected data to a
// scoreboard, a negedge monitor pops and compares on o_rdata_vld.
`timescale 1ns/1ps

module tb_irq_ctrl;
    localparam int          N_SRC       = 8;
    localparam int          SYNC_STAGES = 2;
    localparam logic [15:0] BASE        = 16'hFF00;

    logic             clk = 1'b0;
    logic             n_rst;
    logic [N_SRC-1:0] src;
    logic             inta;
    logic             intb;

    irq_ctrl_if bus ();

    irq_ctrl #(
        .N_SRC      (N_SRC),
        .SYNC_STAGES(SYNC_STAGES),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .i_irq_src(src),
        .bus      (bus),
        .o_inta   (inta),
        .o_intb   (intb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] sb_val[$];
    string       sb_tag[$];
    logic [15:0] mon_val;
    string       mon_tag;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every valid read beat against the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.o_rdata_vld === 1'b1) begin
            if (sb_val.size() == 0) begin
                check_val("sb_underflow", 32'(sb_val.size()), 32'd1);
            end else begin
                mon_val = sb_val.pop_front();
                mon_tag = sb_tag.pop_front();
                check_val(mon_tag, {16'h0000, bus.o_rdata}, {16'h0000, mon_val});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        bus.i_sel   = 1'b1;
        bus.i_rw    = 1'b0;
        bus.i_addr  = addr;
        bus.i_wdata = data;
        tick();
        bus.i_sel   = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, input logic [15:0] exp, input string tag);
        sb_val.push_back(exp);
        sb_tag.push_back(tag);
        bus.i_sel  = 1'b1;
        bus.i_rw   = 1'b1;
        bus.i_addr = addr;
        tick();
        bus.i_sel  = 1'b0;
    endtask

    task automatic bus_read_nv(input logic [15:0] addr, input string tag);
        bus.i_sel  = 1'b1;
        bus.i_rw   = 1'b1;
        bus.i_addr = addr;
        tick();
        bus.i_sel  = 1'b0;
        check_val(tag, 32'(bus.o_rdata_vld), 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst       = 1'b0;
        src         = '0;
        bus.i_sel   = 1'b0;
        bus.i_rw    = 1'b0;
        bus.i_addr  = 16'h0000;
        bus.i_wdata = 16'h0000;
        #12;
        check_val("rst_inta", 32'(inta), 32'd0);
        check_val("rst_intb", 32'(intb), 32'd0);
        check_val("rst_vld", 32'(bus.o_rdata_vld), 32'd0);
        check_val("rst_rdata", {16'h0000, bus.o_rdata}, 32'h0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Latency: PEND after edge 2, o_inta after edge 3
        bus_write(BASE + 16'd1, 16'h0001);
        bus_write(BASE + 16'd2, 16'h0000);
        src[0] = 1'b1;
        tick();
        tick();
        bus_read(BASE, 16'h0000, "lat_pend_e2");
        check_val("lat_inta_e2", 32'(inta), 32'd0);
        bus_read(BASE, 16'h0001, "lat_pend_e3");
        check_val("lat_inta_e3", 32'(inta), 32'd1);
        check_val("lat_intb_e3", 32'(intb), 32'd0);
        bus_write(BASE, 16'h0001);
        tick();
        check_val("lat_level_one_event", 32'(inta), 32'd0);
        src[0] = 1'b0;

        // Routing and priority with claim sequence
        bus_write(BASE + 16'd1, 16'h00FF);
        bus_write(BASE + 16'd2, 16'h0020);
        src[2] = 1'b1;
        src[5] = 1'b1;
        tick();
        src[2] = 1'b0;
        src[5] = 1'b0;
        repeat (4) tick();
        check_val("route_inta", 32'(inta), 32'd1);
        check_val("route_intb", 32'(intb), 32'd1);
        bus_read(BASE + 16'd3, 16'd5, "vec_5");
        bus_read(BASE + 16'd4, 16'd5, "claim_5");
        bus_read(BASE + 16'd4, 16'd2, "claim_2");
        bus_read(BASE + 16'd4, 16'h00FF, "claim_none");
        check_val("claim_inta_fall", 32'(inta), 32'd0);
        check_val("claim_intb_fall", 32'(intb), 32'd0);
        bus_read(BASE, 16'h0000, "claim_pend_empty");

        // W1C colliding with a new edge, then plain W1C
        src[3] = 1'b1;
        tick();
        src[3] = 1'b0;
        repeat (4) tick();
        bus_read(BASE, 16'h0008, "w1c_pend_set");
        src[3] = 1'b1;
        tick();
        tick();
        bus_write(BASE, 16'h0008);
        bus_read(BASE, 16'h0008, "w1c_set_wins");
        check_val("w1c_inta_on", 32'(inta), 32'd1);
        src[3] = 1'b0;
        bus_write(BASE, 16'h0008);
        check_val("w1c_inta_hold", 32'(inta), 32'd1);
        tick();
        check_val("w1c_inta_fall", 32'(inta), 32'd0);
        bus_read(BASE, 16'h0000, "w1c_pend_clear");

        // Masking and route change
        src[1] = 1'b1;
        tick();
        src[1] = 1'b0;
        repeat (4) tick();
        check_val("mask_inta_on", 32'(inta), 32'd1);
        bus_write(BASE + 16'd1, 16'h0000);
        check_val("mask_inta_hold", 32'(inta), 32'd1);
        tick();
        check_val("mask_inta_off", 32'(inta), 32'd0);
        bus_read(BASE, 16'h0002, "mask_pend_kept");
        bus_read(BASE + 16'd3, 16'h00FF, "mask_vec_none");
        bus_write(BASE + 16'd1, 16'h0002);
        check_val("unmask_inta_wait", 32'(inta), 32'd0);
        tick();
        check_val("unmask_inta_on", 32'(inta), 32'd1);
        bus_write(BASE + 16'd2, 16'h0002);
        tick();
        check_val("reroute_intb", 32'(intb), 32'd1);
        check_val("reroute_inta", 32'(inta), 32'd0);
        bus_write(BASE + 16'd2, 16'h0000);
        bus_write(BASE, 16'hFFFF);
        tick();
        check_val("clear_inta", 32'(inta), 32'd0);
        check_val("clear_intb", 32'(intb), 32'd0);

        // Bus decode boundaries
        bus_write(BASE + 16'd5, 16'h00FF);
        bus_write(BASE - 16'd1, 16'h00FF);
        bus_read_nv(BASE + 16'd5, "oor_hi_vld");
        bus_read_nv(BASE - 16'd1, "oor_lo_vld");
        bus_read(BASE + 16'd1, 16'h0002, "oor_en_unchanged");
        bus_write(BASE + 16'd1, 16'h00A5);
        bus_read(BASE + 16'd1, 16'h00A5, "en_readback");
        tick();
        check_val("vld_pulse_end", 32'(bus.o_rdata_vld), 32'd0);
        check_val("rdata_hold", {16'h0000, bus.o_rdata}, 32'h00A5);
        bus_write(BASE + 16'd1, 16'hFFFF);
        bus_read(BASE + 16'd1, 16'h00FF, "en_upper_ignored");
        bus_write(BASE + 16'd2, 16'hFF00);
        bus_read(BASE + 16'd2, 16'h0000, "route_upper_ignored");

        // Asynchronous reset mid-operation
        bus_write(BASE + 16'd1, 16'h0050);
        src[6] = 1'b1;
        tick();
        src[6] = 1'b0;
        src[4] = 1'b1;
        repeat (4) tick();
        check_val("pre_rst_inta", 32'(inta), 32'd1);
        bus_read(BASE + 16'd1, 16'h0050, "pre_rst_en");
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        check_val("arst_inta", 32'(inta), 32'd0);
        check_val("arst_intb", 32'(intb), 32'd0);
        check_val("arst_vld", 32'(bus.o_rdata_vld), 32'd0);
        check_val("arst_rdata", {16'h0000, bus.o_rdata}, 32'h0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (5) tick();
        bus_write(BASE + 16'd1, 16'h0010);
        bus_read(BASE, 16'h0010, "held_src_pend");
        check_val("held_src_inta", 32'(inta), 32'd1);
        bus_read(BASE + 16'd4, 16'd4, "held_src_claim");
        repeat (5) tick();
        bus_read(BASE, 16'h0000, "held_src_single");
        check_val("held_src_inta_off", 32'(inta), 32'd0);
        src[4] = 1'b0;

        tick();
        check_val("sb_drain", 32'(sb_val.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller directly upstream of the CPU core; produces the core's two interrupt request lines (inta = normal, intb = high priority).
- Synchronizes N asynchronous interrupt sources, detects rising edges, latches pending bits, applies enable/routing masks, exposes a small memory-mapped register file on the CPU external bus, and supports atomic claim.
- The system top decodes the bus and resolves the tristate data bus into split read/write data.

Parameters:
- N_SRC, 8, number of interrupt sources (1..16)
- SYNC_STAGES, 2, synchronizer flops per source (>=2)
- BASE_ADDR, 16'hFF00, word address of register 0

Ports:
- clk  input  1  system/CPU clock
- n_rst  input  1  asynchronous active-low reset
- i_irq_src  input  N_SRC  raw asynchronous interrupt sources, rising-edge sensitive
- i_sel  input  1  bus cycle valid this clock
- i_rw  input  1  1 = read, 0 = write
- i_addr  input  16  bus word address
- i_wdata  input  16  write data
- o_rdata  output  16  read data, registered
- o_rdata_vld  output  1  one-cycle pulse, o_rdata valid
- o_inta  output  1  normal-priority request, level, registered
- o_intb  output  1  high-priority request, level, registered

Behaviour:
- Reset (n_rst low, asynchronous): sync chains, edge-detect history, PEND, EN, ROUTE, o_rdata, o_rdata_vld, o_inta and o_intb all go to 0.
- Because history resets to 0, a source already high at reset release produces exactly one pending event.
- Register map (offset from BASE_ADDR; bits above N_SRC read 0 and ignore writes):
  - 0 PEND: read; write-1-to-clear
  - 1 EN: read/write
  - 2 ROUTE: read/write; bit = 1 routes that source to intb, 0 to inta
  - 3 VEC: read-only; index of the winning source, or 16'h00FF if none
  - 4 CLAIM: read returns VEC and clears that PEND bit in the same edge; writes ignored
- Winner selection: consider sources with PEND & EN. Any ROUTE = 1 candidate beats all ROUTE = 0 candidates; within a group, the lowest index wins.
- Edge detect: rise[i] = sync_out[i] & ~hist[i]; hist updates every cycle.
- Latency: a source rising before edge 0 is seen at sync output after edge SYNC_STAGES-1. PEND sets at edge SYNC_STAGES. o_inta/o_intb update at edge SYNC_STAGES+1.
- Outputs:
  - o_intb <= |(PEND & EN & ROUTE)
  - o_inta <= |(PEND & EN & ~ROUTE)
  - Both registered, updated every cycle.
- Pulse rule: pulses narrower than one clk period may be lost. A level held high produces one event only.
- Writes: take effect at the edge where i_sel=1, i_rw=0 and the address is in range.
- Reads: with i_sel=1, i_rw=1 and the address in range, o_rdata and o_rdata_vld=1 are registered at that edge (1-cycle latency). o_rdata_vld is 0 otherwise; o_rdata holds its last value.
- Out-of-range addresses: no state change, no o_rdata_vld.
- Simultaneous set/clear on the same bit (W1C or CLAIM in the same cycle as a new rise): set wins, bit stays 1.
- CLAIM with no candidate: returns 16'h00FF, no state change.
- EN cleared while PEND is set: PEND is retained and the request deasserts on the next edge. Re-enabling reasserts it.
- ROUTE change: moves an active request between lines on the next edge.
- Back-to-back bus cycles on every clock are legal; each read observes state from before that edge.

Test Plan:
- Reset/latency: SYNC_STAGES=2, EN=16'h0001, ROUTE=0; raise src[0] before edge 0 -> PEND[0]=1 after edge 2, o_inta=1 after edge 3, o_intb=0.
- Routing/priority: EN=16'h00FF, ROUTE=16'h0020; pulse src[2] and src[5] -> o_inta=1, o_intb=1. Read VEC -> 5; CLAIM -> 5, then CLAIM -> 2, then CLAIM -> 16'h00FF; both lines fall.
- W1C vs new edge: PEND[3]=1, write PEND=16'h0008 in the same cycle src[3] edge reaches PEND -> PEND[3] stays 1. Repeat without the edge -> PEND[3]=0 and o_inta falls one edge later.
- Masking: PEND[1]=1, EN=0 -> o_inta=0. Write EN=16'h0002 -> o_inta=1 one edge later.
- Bus decode: read BASE_ADDR+5 and BASE_ADDR-1 -> o_rdata_vld stays 0, no state change. Read EN immediately after writing EN=16'h00A5 -> 16'h00A5 with o_rdata_vld one cycle after the read.
- Asynchronous reset mid-operation: assert n_rst low between edges with PEND/EN nonzero -> all outputs 0 immediately. Release with src[4] held high and EN[4] set -> one PEND[4] event only.
